sc_result_fifo: RTL and testbench
=================================

Name: sc_result_fifo

Overview:
- Downstream stage of the stochastic-computing datapath. Consumes the 9-bit `result` and its `en_out` qualifier produced by the SC→NAND→ADD chain.
- Captures exactly one sample per enable assertion into a small show-ahead FIFO, then presents it on a valid/ready handshake to the system side.
- Tracks the number of frames captured and dropped so software and the testbench can detect back-pressure loss.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- DW, 9, sample width; matches the ADD output width
- CNT_W, 16, width of the frame and drop counters

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset; rst=0 resets all state immediately
- en_in  in  1  result qualifier from the ADD stage; level may stay high for several cycles
- result_in  in  DW  sample from the ADD stage; valid while en_in=1
- clr  in  1  synchronous flush; active-high
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts the head entry
- out_data  out  DW  head entry (show-ahead)
- count  out  $clog2(DEPTH)+1  current occupancy
- full  out  1  count==DEPTH
- overflow  out  1  sticky; a sample was dropped
- frame_cnt  out  CNT_W  samples written
- drop_cnt  out  CNT_W  samples dropped, saturating

Behaviour:
- Reset (rst=0, async): all of the following go to 0 — out_valid, out_data, count, full, overflow, frame_cnt, drop_cnt, wr_ptr, rd_ptr, en_d.
- Capture event: cap = en_in & ~en_d, where en_d is en_in registered.
  - A held-high en_in produces one capture only.
  - en_in already high when reset releases: en_d=0 after reset, so one capture occurs on the first active cycle.
- Push: on a cap cycle N, result_in is sampled at the end of cycle N.
  - If the FIFO was empty, out_valid=1 and out_data=sample in cycle N+1 (latency 1).
- Pop: out_valid & out_ready in a cycle advances rd_ptr at the end of that cycle; the next head appears in the following cycle.
- out_data is stable while out_valid=1 and out_ready=0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count increments on push only, decrements on pop only, and is unchanged when both occur.
- Full with cap and a pop in the same cycle: the pop frees a slot and the push is accepted; count stays DEPTH; no drop.
- Full with cap and no pop: the sample is discarded.
  - overflow←1 (sticky until reset or clr).
  - drop_cnt+1, saturating at all-ones.
  - frame_cnt unchanged.
- Empty with out_ready=1: no effect. A pop is never issued while out_valid=0.
- frame_cnt increments on every accepted push and wraps modulo 2^CNT_W.
- clr=1 (sync):
  - Resets pointers, count, overflow and drop_cnt; out_valid=0 in the next cycle.
  - frame_cnt is preserved.
  - A cap in the same cycle is discarded and not counted.
  - en_d still updates, so a held en_in does not re-capture after clr.
- full = (count==DEPTH). out_valid = (count!=0). Both are registered-derived, with no combinational path from out_ready.
- Storage is a DEPTH×DW register array; no reset is required on the array contents.

Decomposition:
- Shared package (sc_pkg):
  - SC_RES_W=9
  - SC_NUM_W=6
  - typedef sc_result_t as logic [SC_RES_W-1:0]
- One natural sub-module: sc_edge_det (en_in → cap pulse, async active-low reset). Reusable for the NAND/ADD enable chain.
- FIFO storage and pointer logic stay inline.

Test Plan:
- Reset, then en_in pulse (1 cycle) with result_in=9'd37 → out_valid=1 the next cycle, out_data=37, count=1, frame_cnt=1; pop with out_ready=1 → out_valid=0, count=0.
- en_in held high for 10 cycles with result_in changing each cycle (start 5) → exactly one entry, value 5; frame_cnt=1.
- out_ready=0, five distinct pulses (10,20,30,40,50) with DEPTH=4 → full=1, count=4, overflow=1, drop_cnt=1; draining yields 10,20,30,40 in order.
- FIFO full, cap and pop in the same cycle (push 60) → count stays 4, drop_cnt unchanged; the drain order ends with 60.
- Fill 3 entries, assert clr → next cycle count=0, out_valid=0, overflow=0, drop_cnt=0, frame_cnt=3 retained.
- Three entries queued, then rst pulled low mid-stream asynchronously → all outputs 0 before the next clk edge; after release, the first en_in pulse is captured normally.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath.
// The widths here are the common currency between the SC, NAND, ADD and result stages.
package sc_pkg;

    // Width of the ADD stage result and of every sample stored downstream
    localparam int SC_RES_W = 9;

    // Width of the stochastic numbers fed into the SC stage
    localparam int SC_NUM_W = 6;

    typedef logic [SC_RES_W-1:0] sc_result_t;

endpackage : sc_pkg

// File: rtl/sc_result_fifo_if.sv
// Valid/ready output channel of the result FIFO.
// The FIFO owns valid and data. The consumer owns ready.
interface sc_result_fifo_if
    import sc_pkg::*;
#(
    parameter int DW = SC_RES_W
) ();

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    // Producer side (the FIFO)
    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Consumer side (system bus / software bridge)
    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface : sc_result_fifo_if

// File: rtl/sc_edge_det.sv
// Rising-edge detector for a level enable.
// A level that stays high for many cycles yields a single-cycle cap pulse
// in the first cycle only. The same block can serve the NAND/ADD enable chain.
module sc_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic cap_o
);

    logic en_q;

    // Remember last cycle's enable level; cleared by the async active-low reset
    // so an enable already high at reset release still produces one capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en_i;
        end
    end

    assign cap_o = en_i & ~en_q;

endmodule : sc_edge_det

// File: rtl/sc_result_fifo.sv
// Result capture FIFO at the end of the SC -> NAND -> ADD chain.
// Captures one sample per enable assertion into a show-ahead FIFO, offers the
// head on a valid/ready channel, and keeps frame/drop statistics so lost
// samples caused by back-pressure are visible.
module sc_result_fifo
    import sc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = SC_RES_W,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_in,
    input  logic [DW-1:0]          result_in,
    input  logic                   clr,
    sc_result_fifo_if.master       out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0]    mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic cap;
    logic is_empty;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

    sc_edge_det u_edge_det (
        .clk   (clk),
        .rst   (rst),
        .en_i  (en_in),
        .cap_o (cap)
    );

    // Status comes from the registered occupancy only, so nothing here depends
    // combinationally on out_ready.
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // A pop needs a head entry. A push is allowed when there is room, or when a
    // pop in the same cycle frees the slot being written. A flush discards any
    // capture in the same cycle without counting it.
    assign pop  = ~is_empty & out.out_ready;
    assign push = cap & ~clr & (~is_full | pop);
    assign drop = cap & ~clr & is_full & ~pop;

    // Next-state for pointers, occupancy and statistics; flush wins over traffic
    // except for the frame counter, which survives a flush.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d    = wr_ptr_q + 1'b1;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
        end
    end

    // Control and statistics registers, cleared immediately by the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Sample storage. Contents need no reset because the data output is masked
    // whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= result_in;
        end
    end

    // Show-ahead head entry. It is held stable while it waits for out_ready,
    // and it is forced to zero when the FIFO is empty, including during reset.
    assign out.out_valid = ~is_empty;
    assign out.out_data  = is_empty ? '0 : mem_q[rd_ptr_q];

    assign count     = count_q;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule : sc_result_fifo

// File: tb/tb_sc_result_fifo.sv
// Bench for sc_result_fifo. A table of single-cycle vectors covers the basic
// push/pop, overflow, simultaneous push-on-full and flush cases. Short
// hand-written sequences then cover a held enable and an asynchronous reset.
module tb_sc_result_fifo;

    import sc_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = SC_RES_W;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             enIn;
    logic [DW-1:0]    resultIn;
    logic             clr;
    logic [2:0]       count;
    logic             full;
    logic             overflow;
    logic [CNT_W-1:0] frameCnt;
    logic [CNT_W-1:0] dropCnt;

    sc_result_fifo_if #(.DW(DW)) outIf ();

    sc_result_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_in     (enIn),
        .result_in (resultIn),
        .clr       (clr),
        .out       (outIf),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .frame_cnt (frameCnt),
        .drop_cnt  (dropCnt)
    );

    typedef struct {
        logic       en;
        int         res;
        logic       clr;
        logic       ready;
        logic       expValid;
        int         expData;
        int         expCount;
        logic       expFull;
        logic       expOvf;
        int         expFrame;
        int         expDrop;
    } vec_t;

    vec_t vecs[$];
    int   errors;
    int   checks;

    // 100 MHz free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value against its hand-computed expectation
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive inputs for one cycle; return 1 time unit after the capturing edge
    task automatic applyStimulus(input logic en, input int res, input logic c, input logic ready);
        enIn            = en;
        resultIn        = DW'(res);
        clr             = c;
        outIf.out_ready = ready;
        @(posedge clk);
        #1;
    endtask

    // Check every observable output against one expected set
    task automatic checkAll(input string tag, input logic v, input int d, input int cnt,
                            input logic f, input logic o, input int fr, input int dr);
        checkOutput({tag, " valid"}, int'(outIf.out_valid), int'(v));
        checkOutput({tag, " data"}, int'(outIf.out_data), d);
        checkOutput({tag, " count"}, int'(count), cnt);
        checkOutput({tag, " full"}, int'(full), int'(f));
        checkOutput({tag, " overflow"}, int'(overflow), int'(o));
        checkOutput({tag, " frame_cnt"}, int'(frameCnt), fr);
        checkOutput({tag, " drop_cnt"}, int'(dropCnt), dr);
    endtask

    task automatic addVec(input logic en, input int res, input logic c, input logic ready,
                          input logic v, input int d, input int cnt, input logic f,
                          input logic o, input int fr, input int dr);
        vec_t t;
        t.en = en; t.res = res; t.clr = c; t.ready = ready;
        t.expValid = v; t.expData = d; t.expCount = cnt; t.expFull = f;
        t.expOvf = o; t.expFrame = fr; t.expDrop = dr;
        vecs.push_back(t);
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst             = 1'b0;
        enIn            = 1'b0;
        resultIn        = '0;
        clr             = 1'b0;
        outIf.out_ready = 1'b0;

        // Expected state after each vector's clock edge
        //      en res clr rdy   valid data cnt full ovf frame drop
        addVec(1, 37, 0, 0,    1, 37, 1, 0, 0, 1, 0);  // single pulse captured
        addVec(0,  0, 0, 1,    0,  0, 0, 0, 0, 1, 0);  // popped, empty again
        addVec(1, 10, 0, 0,    1, 10, 1, 0, 0, 2, 0);
        addVec(0,  0, 0, 0,    1, 10, 1, 0, 0, 2, 0);  // head stable while not ready
        addVec(1, 20, 0, 0,    1, 10, 2, 0, 0, 3, 0);
        addVec(0,  0, 0, 0,    1, 10, 2, 0, 0, 3, 0);
        addVec(1, 30, 0, 0,    1, 10, 3, 0, 0, 4, 0);
        addVec(0,  0, 0, 0,    1, 10, 3, 0, 0, 4, 0);
        addVec(1, 40, 0, 0,    1, 10, 4, 1, 0, 5, 0);  // now full
        addVec(0,  0, 0, 0,    1, 10, 4, 1, 0, 5, 0);
        addVec(1, 50, 0, 0,    1, 10, 4, 1, 1, 5, 1);  // 50 dropped
        addVec(0,  0, 0, 0,    1, 10, 4, 1, 1, 5, 1);
        addVec(1, 60, 0, 1,    1, 20, 4, 1, 1, 6, 1);  // pop 10 and push 60 together
        addVec(0,  0, 0, 1,    1, 30, 3, 0, 1, 6, 1);
        addVec(0,  0, 0, 1,    1, 40, 2, 0, 1, 6, 1);
        addVec(0,  0, 0, 1,    1, 60, 1, 0, 1, 6, 1);
        addVec(0,  0, 0, 1,    0,  0, 0, 0, 1, 6, 1);  // drained, overflow still sticky
        addVec(0,  0, 0, 1,    0,  0, 0, 0, 1, 6, 1);  // pop on empty is ignored
        addVec(1, 70, 0, 0,    1, 70, 1, 0, 1, 7, 1);
        addVec(0,  0, 0, 0,    1, 70, 1, 0, 1, 7, 1);
        addVec(1, 80, 0, 0,    1, 70, 2, 0, 1, 8, 1);
        addVec(0,  0, 0, 0,    1, 70, 2, 0, 1, 8, 1);
        addVec(1, 90, 0, 0,    1, 70, 3, 0, 1, 9, 1);
        addVec(0,  0, 1, 0,    0,  0, 0, 0, 0, 9, 0);  // flush keeps frame_cnt
        addVec(1, 99, 1, 0,    0,  0, 0, 0, 0, 9, 0);  // capture during flush discarded
        addVec(1, 98, 0, 0,    0,  0, 0, 0, 0, 9, 0);  // held enable does not re-capture
        addVec(0,  0, 0, 0,    0,  0, 0, 0, 0, 9, 0);

        // Reset state, both while asserted and just after release
        repeat (2) @(posedge clk);
        #1;
        checkAll("in reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAll("after reset", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].res, vecs[i].clr, vecs[i].ready);
            checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expData,
                     vecs[i].expCount, vecs[i].expFull, vecs[i].expOvf,
                     vecs[i].expFrame, vecs[i].expDrop);
        end

        // Enable held for ten cycles with changing data: only the first sample lands
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 5 + i, 1'b0, 1'b0);
        end
        checkAll("held en", 1, 5, 1, 0, 0, 10, 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkAll("held en drain", 0, 0, 0, 0, 0, 10, 0);

        // Queue three entries, then pull reset low in the middle of a cycle
        applyStimulus(1'b1, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkAll("queued three", 1, 1, 3, 0, 0, 13, 0);
        #3;
        rst = 1'b0;
        #1;
        checkAll("async reset", 0, 0, 0, 0, 0, 0, 0);

        // Enable already high while reset is asserted: one capture after release
        enIn     = 1'b1;
        resultIn = DW'(123);
        @(posedge clk);
        #1;
        checkAll("reset held", 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAll("post reset cap", 1, 123, 1, 0, 0, 1, 0);
        applyStimulus(1'b1, 124, 1'b0, 1'b1);
        checkAll("post reset pop", 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sc_result_fifo
